manchester_encoder: RTL and testbench



---
 rtl/manchester_pkg.sv | 11 +
 rtl/manchester_encoder_if.sv | 8 +
 rtl/manchester_half_bit_timer.sv | 23 ++
 rtl/manchester_encoder.sv | 71 +++++++
 tb/tb_manchester_encoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/manchester_pkg.sv
// manchester_pkg: line-coding constants and FSM states shared by the Manchester encoder and decoder
package manchester_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;
  localparam logic MANCH_ONE_FIRST_HALF = 1'b0;
  localparam logic MANCH_IDLE_LEVEL = 1'b0;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/manchester_encoder_if.sv
// manchester_encoder_if: AXI-Stream word handshake into the encoder
interface manchester_encoder_if #(parameter int FRAME_SIZE = 8);
  logic [FRAME_SIZE-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/manchester_half_bit_timer.sv
// manchester_half_bit_timer: paces half-bits, strobing on the last cycle of each half and tracking which half is active
module manchester_half_bit_timer #(
  parameter int HALF_BIT_CYCLES = 2
) (
  input  logic aclk,
  input  logic reset,
  input  logic enable,
  output logic half_tick,
  output logic second_half
);
  localparam int TW = $clog2(HALF_BIT_CYCLES) + 1;
  logic [TW-1:0] cnt;
  assign half_tick = enable && cnt == TW'(HALF_BIT_CYCLES - 1);
  always_ff @(posedge aclk) begin
    if (reset || !enable) begin
      cnt <= '0;
      second_half <= 1'b0;
    end else begin
      cnt <= half_tick ? '0 : cnt + TW'(1);
      second_half <= second_half ^ half_tick;
    end
  end
endmodule

// File: rtl/manchester_encoder.sv
// manchester_encoder: serialises AXI-Stream words as preamble + MSB-first data + idle gap, Manchester coded
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int FRAME_SIZE = 8,
  parameter int HALF_BIT_CYCLES = 2,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_BITS = 2
) (
  input  logic aclk,
  input  logic reset,
  manchester_encoder_if.slave s_axis,
  output logic serial_out,
  output logic busy
);
  localparam int BW = $clog2(max3(PREAMBLE_BITS, FRAME_SIZE, GAP_BITS)) + 1;
  state_t state, state_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [FRAME_SIZE-1:0] shreg, shreg_nx;
  logic half_tick, second_half, bit_end, last_bit, accept, line_bit, line_level;

  manchester_half_bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) timer (
    .aclk(aclk),
    .reset(reset),
    .enable(state != IDLE),
    .half_tick(half_tick),
    .second_half(second_half)
  );

  assign bit_end = half_tick && second_half;
  assign last_bit = bit_cnt == BW'(state == PREAMBLE ? PREAMBLE_BITS - 1 :
                                   state == DATA ? FRAME_SIZE - 1 : GAP_BITS - 1);
  // The last gap cycle doubles as an accept slot so held tvalid streams with no idle cycle
  assign s_axis.tready = !reset && (state == IDLE || (state == GAP && bit_end && last_bit));
  assign accept = s_axis.tvalid && s_axis.tready;
  assign line_bit = state == PREAMBLE ? ~bit_cnt[0] : shreg[FRAME_SIZE-1];
  assign line_level = (state == PREAMBLE || state == DATA)
                    ? (line_bit ? MANCH_ONE_FIRST_HALF : ~MANCH_ONE_FIRST_HALF) ^ second_half
                    : MANCH_IDLE_LEVEL;

  always_comb begin
    state_nx = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx = shreg;
    if (accept) begin
      state_nx = PREAMBLE;
      bit_cnt_nx = '0;
      shreg_nx = s_axis.tdata;
    end else if (bit_end) begin
      bit_cnt_nx = last_bit ? '0 : bit_cnt + BW'(1);
      shreg_nx = state == DATA ? shreg << 1 : shreg;
      state_nx = !last_bit ? state : state == PREAMBLE ? DATA : state == DATA ? GAP : IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      serial_out <= MANCH_IDLE_LEVEL;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg <= shreg_nx;
      serial_out <= line_level;
      busy <= state != IDLE;
    end
  end
endmodule

// File: tb/tb_manchester_encoder.sv
// tb_manchester_encoder: randomized checks of the encoder line against a per-cycle frame model and a blind decoder
module tb_manchester_encoder;
  import manchester_pkg::*;
  localparam int FS = 8, H = 2, PRE = 4, GAP = 2;
  localparam int FRAME_CYC = (PRE + FS + GAP) * 2 * H;
  logic aclk = 1'b0, reset = 1'b1;
  logic serial_out, busy;
  int n_cmp = 0, n_bad = 0;
  logic mon_en = 1'b0, prev_busy = 1'b0;
  logic line_buf [FRAME_CYC];
  int pos = 0;
  logic [FS-1:0] got_q[$];

  manchester_encoder_if #(.FRAME_SIZE(FS)) s_axis ();
  manchester_encoder #(.FRAME_SIZE(FS), .HALF_BIT_CYCLES(H), .PREAMBLE_BITS(PRE), .GAP_BITS(GAP)) dut (
    .aclk(aclk), .reset(reset), .s_axis(s_axis), .serial_out(serial_out), .busy(busy));

  always #5 aclk = ~aclk;

  // Expected line level j cycles after the first preamble sample of a frame carrying w
  function automatic logic ref_level(input logic [FS-1:0] w, input int j);
    int b, half;
    logic v;
    if (j >= (PRE + FS) * 2 * H) return 1'b0;
    b = j / (2 * H);
    half = (j / H) % 2;
    v = b < PRE ? (b % 2 == 0) : w[FS-1-(b-PRE)];
    return half ? v : ~v;
  endfunction

  function automatic logic [FS-1:0] decode_buf();
    logic [FS-1:0] w;
    for (int d = 0; d < FS; d++) w[FS-1-d] = line_buf[(PRE + d) * 2 * H + H];
    return w;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
    if (mon_en) begin
      if (busy) begin
        if (!prev_busy) pos = 0;
        line_buf[pos] = serial_out;
        pos++;
        if (pos == FRAME_CYC) begin
          got_q.push_back(decode_buf());
          pos = 0;
        end
      end
      prev_busy = busy;
    end
  endtask

  task automatic handshake(input logic [FS-1:0] w, output bit ok);
    s_axis.tdata = w;
    s_axis.tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      if (s_axis.tready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata = FS'($urandom);
    repeat (3) begin
      tick();
      n_cmp++;
      if ({serial_out, s_axis.tready, busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_hold: out/tready/busy=%b%b%b want 000", serial_out, s_axis.tready, busy);
      end
    end
    reset = 1'b0;
    s_axis.tvalid = 1'b0;
    #1;
    n_cmp++;
    if (s_axis.tready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_tready: got %b want 1", s_axis.tready);
    end
    tick();
    n_cmp++;
    if ({serial_out, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle: out/busy=%b%b want 00", serial_out, busy);
    end
  endtask

  task automatic test_frame(input logic [FS-1:0] w);
    bit ok;
    int busy_cnt = 0;
    handshake(w, ok);
    s_axis.tvalid = 1'b0;
    s_axis.tdata = ~w;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL frame_timeout: word %h never accepted", w);
      return;
    end
    for (int i = 0; i < FRAME_CYC; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      n_cmp++;
      if (serial_out !== ref_level(w, i)) begin
        n_bad++;
        $display("FAIL frame_line word %h cycle %0d: got %b want %b", w, i, serial_out, ref_level(w, i));
      end
      n_cmp++;
      if (s_axis.tready !== (i >= FRAME_CYC - 2)) begin
        n_bad++;
        $display("FAIL frame_tready word %h cycle %0d: got %b want %b", w, i, s_axis.tready, i >= FRAME_CYC - 2);
      end
    end
    tick();
    n_cmp++;
    if (busy_cnt != FRAME_CYC || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_busy word %h: high %0d cycles then %b, want %0d then 0", w, busy_cnt, busy, FRAME_CYC);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic exp;
    handshake(8'h00, ok);
    s_axis.tdata = 8'hFF;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_timeout: first word never accepted");
      s_axis.tvalid = 1'b0;
      return;
    end
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      tick();
      exp = i < FRAME_CYC ? ref_level(8'h00, i) : ref_level(8'hFF, i - FRAME_CYC);
      n_cmp++;
      if (serial_out !== exp || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_line cycle %0d: out/busy=%b%b want %b1", i, serial_out, busy, exp);
      end
      if (i <= FRAME_CYC - 2) begin
        n_cmp++;
        if (s_axis.tready !== (i == FRAME_CYC - 2)) begin
          n_bad++;
          $display("FAIL b2b_tready cycle %0d: got %b want %b", i, s_axis.tready, i == FRAME_CYC - 2);
        end
      end
      if (i == FRAME_CYC - 1) s_axis.tvalid = 1'b0;
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    bit ok, good = 1;
    handshake(8'h81, ok);
    s_axis.tvalid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midrst_timeout: word 81 never accepted");
      return;
    end
    for (int i = 0; i < 21; i++) begin
      tick();
      if (serial_out !== ref_level(8'h81, i)) good = 0;
    end
    n_cmp++;
    if (!good) begin
      n_bad++;
      $display("FAIL midrst_prefix: line diverged before reset, got ok=%b want 1", good);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({serial_out, busy, s_axis.tready} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_abort: out/busy/tready=%b%b%b want 000", serial_out, busy, s_axis.tready);
    end
    reset = 1'b0;
    good = 1;
    repeat (20) begin
      tick();
      if (serial_out !== 1'b0 || busy !== 1'b0) good = 0;
    end
    n_cmp++;
    if (!good) begin
      n_bad++;
      $display("FAIL midrst_quiet: activity after abort, got ok=%b want 1", good);
    end
    test_frame(8'h55);
  endtask

  task automatic test_loopback();
    bit ok;
    int gap;
    got_q.delete();
    pos = 0;
    prev_busy = busy;
    mon_en = 1'b1;
    for (int w = 0; w < 256; w++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        s_axis.tvalid = 1'b0;
        repeat (gap) tick();
      end
      handshake(FS'(w), ok);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL loop_timeout: word %h never accepted", w);
        break;
      end
    end
    s_axis.tvalid = 1'b0;
    for (int t = 0; t < 3 * FRAME_CYC && got_q.size() < 256; t++) tick();
    mon_en = 1'b0;
    n_cmp++;
    if (got_q.size() != 256) begin
      n_bad++;
      $display("FAIL loop_count: decoded %0d words want 256", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== FS'(i)) begin
        n_bad++;
        $display("FAIL loop_word %0d: got %h want %h", i, got_q[i], FS'(i));
      end
    end
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h3C);
    repeat (4) test_frame(FS'($urandom));
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
